// File: rtl/ovf_fifo_drain.sv
// Drains the lossy overflow FIFO into a 2-entry skid buffer, tagging each entry
// with a wrapping sequence number and the count of entries dropped before it.
module ovf_fifo_drain #(
    parameter int DW     = 16,
    parameter int SEQ_W  = 8,
    parameter int DROP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    output logic              in_pop,
    input  logic              drop,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [SEQ_W-1:0]  out_seq,
    output logic [DROP_W-1:0] out_lost,
    input  logic              out_ready
);

    typedef struct packed {
        logic [DW-1:0]     data;
        logic [SEQ_W-1:0]  seq;
        logic [DROP_W-1:0] lost;
    } entry_t;

    localparam logic [DROP_W-1:0] LOST_MAX = '1;

    logic [1:0]        count;
    entry_t            head;
    entry_t            tail;
    logic [SEQ_W-1:0]  seq_cnt;
    logic [DROP_W-1:0] lost_acc;
    logic              deq;
    entry_t            new_entry;

    // Pop depends only on registered occupancy, never on out_ready.
    assign in_pop    = rst & in_valid & ~flush & (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign deq       = out_valid & out_ready;
    assign new_entry = '{data: in_data, seq: seq_cnt, lost: lost_acc};

    assign out_data  = head.data;
    assign out_seq   = head.seq;
    assign out_lost  = head.lost;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the two slots are ordinary flops, so clearing them on reset
            // is cheap and guarantees out_data reads 0 after reset.
            count    <= 2'd0;
            head     <= '0;
            tail     <= '0;
            seq_cnt  <= '0;
            lost_acc <= '0;
        end else if (flush) begin
            count     <= 2'd0;
            seq_cnt   <= '0;
            lost_acc  <= '0;
            head.seq  <= '0;
            head.lost <= '0;
            tail.seq  <= '0;
            tail.lost <= '0;
        end else begin
            count <= count + 2'(in_pop) - 2'(deq);

            if (in_pop) begin
                seq_cnt  <= seq_cnt + SEQ_W'(1);
                // A drop in the pop cycle belongs to the next entry.
                lost_acc <= drop ? DROP_W'(1) : '0;
            end else if (drop && lost_acc != LOST_MAX) begin
                lost_acc <= lost_acc + DROP_W'(1);
            end

            if (in_pop && (count == 2'd0 || (count == 2'd1 && deq))) begin
                head <= new_entry;
            end else if (in_pop && count == 2'd1) begin
                tail <= new_entry;
            end else if (deq && count == 2'd2) begin
                head <= tail;
            end
        end
    end

endmodule

// File: tb/tb_ovf_fifo_drain.sv
// Randomised and directed bench for ovf_fifo_drain with a queue-based
// reference model and a scoreboard monitor sampling on the falling edge.
module tb_ovf_fifo_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_pop;
    logic        drop;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_seq;
    logic [3:0]  out_lost;
    logic        out_ready;

    always #5 clk = ~clk;

    ovf_fifo_drain #(.DW(16), .SEQ_W(8), .DROP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_pop    (in_pop),
        .drop      (drop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_seq   (out_seq),
        .out_lost  (out_lost),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [15:0] d;
        int          s;
        int          l;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [15:0] src[$];
    int          m_seq    = 0;
    int          m_lost   = 0;
    bit          zero_data = 1'b0;
    bit          zero_tags = 1'b0;
    bit          pop_seen  = 1'b0;
    bit          last_flush = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model + scoreboard monitor: inputs are stable at the falling edge.
    always @(negedge clk) begin
        bit exp_pop;
        pop_seen = in_pop;
        if (!rst) begin
            check("pop_in_reset", 32'(in_pop), 32'd0);
            sb.delete();
            m_seq = 0; m_lost = 0;
            zero_data = 1'b1; zero_tags = 1'b1;
        end else if (flush) begin
            check("pop_in_flush", 32'(in_pop), 32'd0);
            sb.delete();
            m_seq = 0; m_lost = 0;
            zero_tags = 1'b1;
        end else begin
            exp_pop = in_valid && (sb.size() < 2);
            check("in_pop", 32'(in_pop), 32'(exp_pop));
            check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                check("out_data", 32'(out_data), 32'(sb[0].d));
                check("out_seq", 32'(out_seq), 32'(sb[0].s));
                check("out_lost", 32'(out_lost), 32'(sb[0].l));
                if (out_ready) void'(sb.pop_front());
            end else begin
                if (zero_tags) begin
                    check("idle_seq", 32'(out_seq), 32'd0);
                    check("idle_lost", 32'(out_lost), 32'd0);
                end
                if (zero_data) check("idle_data", 32'(out_data), 32'd0);
            end
            if (exp_pop) begin
                sb.push_back('{d: in_data, s: m_seq, l: m_lost});
                m_seq  = (m_seq + 1) % 256;
                m_lost = drop ? 1 : 0;
                zero_data = 1'b0; zero_tags = 1'b0;
            end else if (drop) begin
                m_lost = (m_lost < 15) ? m_lost + 1 : 15;
            end
        end
    end

    // One clock of stimulus; the upstream FIFO model is the src queue.
    task automatic step(input bit rst_i, input bit flush_i, input bit drop_i,
                        input bit ready_i, input bit valid_en);
        @(posedge clk);
        #1;
        if (pop_seen && src.size() != 0) void'(src.pop_front());
        if (last_flush) src.delete();
        rst       = rst_i;
        flush     = flush_i;
        drop      = drop_i;
        out_ready = ready_i;
        in_valid  = valid_en && (src.size() != 0);
        in_data   = (src.size() != 0) ? src[0] : 16'(($urandom));
        last_flush = flush_i;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || src.size() != 0) && n < 40) begin
            step(1, 0, 0, 1, 1);
            n++;
        end
        check("drain_timeout", 32'(sb.size() + src.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; drop = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_data = '0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Streaming at full rate.
        for (int i = 0; i < 10; i++) src.push_back(16'hA000 + 16'(i));
        repeat (12) step(1, 0, 0, 1, 1);
        drain();

        // Backpressure then release.
        src.push_back(16'h1111); src.push_back(16'h2222); src.push_back(16'h3333);
        repeat (4) step(1, 0, 0, 0, 1);
        repeat (5) step(1, 0, 0, 1, 1);
        drain();

        // Drop accounting, including a drop coincident with a pop.
        repeat (3) step(1, 0, 1, 1, 1);
        src.push_back(16'h5555); src.push_back(16'h6666);
        repeat (4) step(1, 0, 0, 1, 1);
        src.push_back(16'h7777);
        step(1, 0, 1, 1, 1);
        step(1, 0, 0, 1, 1);
        src.push_back(16'h8888);
        repeat (3) step(1, 0, 0, 1, 1);
        repeat (20) step(1, 0, 1, 1, 0);
        src.push_back(16'h9999);
        repeat (3) step(1, 0, 0, 1, 1);
        drain();

        // Sequence wrap across 258 entries.
        for (int i = 0; i < 258; i++) src.push_back(16'(i));
        repeat (262) step(1, 0, 0, 1, 1);
        drain();

        // Flush with two entries held, drop during flush ignored.
        src.push_back(16'hB001); src.push_back(16'hB002); src.push_back(16'hB003);
        repeat (3) step(1, 0, 0, 0, 1);
        step(1, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0);
        src.push_back(16'hC001);
        repeat (3) step(1, 0, 0, 1, 1);
        drain();

        // Synchronous reset mid-stream.
        for (int i = 0; i < 10; i++) src.push_back(16'hD000 + 16'(i));
        repeat (4) step(1, 0, 0, ($urandom_range(0, 1) == 1), 1);
        step(0, 0, 1, 1, 1);
        repeat (14) step(1, 0, 0, 1, 1);
        drain();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && src.size() < 8) src.push_back(16'($urandom));
            step(($urandom_range(0, 120) != 0), ($urandom_range(0, 60) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 4) != 0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
